// File: rtl/match_pkg.sv
// Shared definitions for the reaction-match sequencer: state codes, winner
// codes, LFSR constants and LED patterns.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_GO   = 3'd3,
    ST_SHOW = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Taps 16,14,13,11 map to bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [3:0] LED_OFF   = 4'b0000;
  localparam logic [3:0] LED_ARMED = 4'b0001;
  localparam logic [3:0] LED_GO    = 4'b0011;
  localparam logic [3:0] LED_DONE  = 4'b1111;

  function automatic logic [3:0] show_led(input logic [1:0] w);
    return {w, 2'b11};
  endfunction

endpackage

// File: rtl/match_sequencer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a maximal-length tap set started from a
// non-zero seed can never fall into the all-zero lock-up state.
module lfsr16
  import match_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Two-player reaction match sequencer: arms each round, waits a random delay,
// lights GO, times both players, scores the round and decides the match.
module match_sequencer
  import match_pkg::*;
#(
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 10,
  parameter int unsigned TIMEOUT_MS   = 1000,
  parameter int unsigned SHOW_MS      = 1000,
  parameter int unsigned SCORE_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_ms,
  input  logic               start_n,
  input  logic               p1_n,
  input  logic               p2_n,
  output logic [3:0]         led,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [15:0]        react_ms,
  output logic               match_done,
  output logic [2:0]         state_o
);

  localparam int unsigned RND_W = $clog2(ROUNDS + 1);
  localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'((ROUNDS + 1) / 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [RND_W-1:0]   ROUNDS_R  = RND_W'(ROUNDS);
  localparam logic [15:0]        TIMEOUT_C = 16'(TIMEOUT_MS);
  localparam logic [15:0]        SHOW_C    = 16'(SHOW_MS);
  localparam logic [15:0]        MIN_DLY_C = 16'(MIN_DELAY_MS);

  state_t           state;
  logic [15:0]      delay_cnt;
  logic [15:0]      react_cnt;
  logic [15:0]      show_cnt;
  logic [RND_W-1:0] round_cnt;
  logic [15:0]      lfsr_q;

  logic             p1_press;
  logic             p2_press;
  logic             end_round;
  logic [1:0]       out_winner;
  logic [15:0]      out_react;
  logic             decided;
  logic             unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:RAND_BITS];
  assign p1_press    = ~p1_n;
  assign p2_press    = ~p2_n;
  assign state_o     = state;

  assign decided = (score1 >= WIN_SCORE) || (score2 >= WIN_SCORE) ||
                   (round_cnt == ROUNDS_R);

  // Resolves whether this cycle closes a round and who takes it; a press beats
  // a timeout, and an expired WAIT delay beats a press so it is never a false start.
  always_comb begin
    end_round  = 1'b0;
    out_winner = WIN_NONE;
    out_react  = '0;
    if (state == ST_WAIT && delay_cnt != '0 && (p1_press ^ p2_press)) begin
      end_round  = 1'b1;
      out_winner = p1_press ? WIN_P2 : WIN_P1;
    end else if (state == ST_GO) begin
      if (p1_press || p2_press) begin
        end_round  = 1'b1;
        out_winner = {p2_press, p1_press};
        out_react  = react_cnt;
      end else if (react_cnt == TIMEOUT_C) begin
        end_round  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      led        <= LED_OFF;
      score1     <= '0;
      score2     <= '0;
      winner     <= WIN_NONE;
      react_ms   <= '0;
      match_done <= 1'b0;
      delay_cnt  <= '0;
      react_cnt  <= '0;
      show_cnt   <= '0;
      round_cnt  <= '0;
    end else if (end_round) begin
      state     <= ST_SHOW;
      led       <= show_led(out_winner);
      winner    <= out_winner;
      react_ms  <= out_react;
      show_cnt  <= '0;
      round_cnt <= round_cnt + 1'b1;
      if (out_winner == WIN_P1 && score1 != SCORE_MAX) begin
        score1 <= score1 + 1'b1;
      end
      if (out_winner == WIN_P2 && score2 != SCORE_MAX) begin
        score2 <= score2 + 1'b1;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!start_n) begin
            state <= ST_ARM;
            led   <= LED_ARMED;
          end
        end
        ST_ARM: begin
          if (p1_n && p2_n) begin
            delay_cnt <= MIN_DLY_C + 16'(lfsr_q[RAND_BITS-1:0]);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (delay_cnt == '0) begin
            state     <= ST_GO;
            led       <= LED_GO;
            react_cnt <= '0;
          end else if (p1_press && p2_press) begin
            state <= ST_ARM;
          end else if (tick_ms) begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        ST_GO: begin
          if (tick_ms) begin
            react_cnt <= react_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (show_cnt == SHOW_C) begin
            if (decided) begin
              state      <= ST_DONE;
              led        <= LED_DONE;
              match_done <= 1'b1;
            end else begin
              state <= ST_ARM;
              led   <= LED_ARMED;
            end
          end else if (tick_ms) begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!start_n) begin
            state      <= ST_IDLE;
            led        <= LED_OFF;
            score1     <= '0;
            score2     <= '0;
            winner     <= WIN_NONE;
            react_ms   <= '0;
            round_cnt  <= '0;
            match_done <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          led   <= LED_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with a 1-cycle ms tick, short WAIT delay
// (10 + lfsr[0] ms) and hand-computed expectations.
module tb_match_sequencer;

  logic        clk;
  logic        rst_n;
  logic        tick_ms;
  logic        start_n;
  logic        p1_n;
  logic        p2_n;
  logic [3:0]  led;
  logic [2:0]  score1;
  logic [2:0]  score2;
  logic [1:0]  winner;
  logic [15:0] react_ms;
  logic        match_done;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lfsr_zero = 0;

  match_sequencer #(
    .ROUNDS       (5),
    .MIN_DELAY_MS (10),
    .RAND_BITS    (1),
    .TIMEOUT_MS   (1000),
    .SHOW_MS      (1000),
    .SCORE_W      (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ms    (tick_ms),
    .start_n    (start_n),
    .p1_n       (p1_n),
    .p2_n       (p2_n),
    .led        (led),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .react_ms   (react_ms),
    .match_done (match_done),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (dut.u_lfsr.q == 16'h0000) lfsr_zero++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic b);
    start_n = s;
    p1_n    = a;
    p2_n    = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges until state_o reaches target, with a cycle budget.
  task automatic waitState(input string tag, input logic [2:0] target, input int budget, output int n);
    n = 0;
    while (state_o !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {29'd0, state_o}, {29'd0, target});
  endtask

  initial begin
    int n;
    int show_len;
    int led_ok;

    rst_n   = 1'b0;
    tick_ms = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(2);
    checkOutput("rst_state", state_o, 3'd0);
    checkOutput("rst_led", led, 4'b0000);
    checkOutput("rst_score1", score1, 3'd0);
    checkOutput("rst_score2", score2, 3'd0);
    checkOutput("rst_winner", winner, 2'b00);
    checkOutput("rst_react", react_ms, 16'd0);
    checkOutput("rst_done", match_done, 1'b0);
    checkOutput("rst_lfsr_seed", dut.u_lfsr.q, 16'hACE1);
    rst_n = 1'b1;

    // Normal round: P1 presses after 7 GO ticks.
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(1);
    checkOutput("arm_state", state_o, 3'd1);
    checkOutput("arm_led", led, 4'b0001);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(1);
    checkOutput("wait_state", state_o, 3'd2);
    waitState("go_reached", 3'd3, 20, n);
    checkOutput("wait_len_in_range", (n >= 11 && n <= 12), 1);
    checkOutput("go_led", led, 4'b0011);
    step(7);
    applyStimulus(1'b1, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("norm_state", state_o, 3'd4);
    checkOutput("norm_winner", winner, 2'b01);
    checkOutput("norm_score1", score1, 3'd1);
    checkOutput("norm_react", react_ms, 16'd7);
    show_len = 0;
    led_ok   = 0;
    while (state_o == 3'd4 && show_len < 1100) begin
      if (led == 4'b0111) led_ok++;
      show_len++;
      step(1);
    end
    checkOutput("show_len", show_len, 1001);
    checkOutput("show_led_cycles", led_ok, 1001);
    checkOutput("show_to_arm", state_o, 3'd1);

    // False start by P2 in WAIT.
    step(1);
    checkOutput("fs_wait", state_o, 3'd2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("fs_state", state_o, 3'd4);
    checkOutput("fs_winner", winner, 2'b01);
    checkOutput("fs_score1", score1, 3'd2);
    checkOutput("fs_score2", score2, 3'd0);
    waitState("fs_to_arm", 3'd1, 1100, n);

    // Both press in the same WAIT cycle: round voided.
    step(1);
    checkOutput("void_wait", state_o, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("void_state", state_o, 3'd1);
    checkOutput("void_score1", score1, 3'd2);
    checkOutput("void_rounds", dut.round_cnt, 2);

    // Both press in the same GO cycle: tie.
    step(1);
    waitState("tie_go", 3'd3, 20, n);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("tie_state", state_o, 3'd4);
    checkOutput("tie_winner", winner, 2'b11);
    checkOutput("tie_led", led, 4'b1111);
    checkOutput("tie_score1", score1, 3'd2);
    checkOutput("tie_score2", score2, 3'd0);
    waitState("tie_to_arm", 3'd1, 1100, n);

    // No press: GO times out after 1000 ticks.
    step(1);
    waitState("to_go", 3'd3, 20, n);
    waitState("to_show", 3'd4, 1100, n);
    checkOutput("to_go_len", n, 1001);
    checkOutput("to_winner", winner, 2'b00);
    checkOutput("to_score1", score1, 3'd2);
    waitState("to_to_arm", 3'd1, 1100, n);

    // Reset in the middle of GO with score1 = 2.
    step(1);
    waitState("mid_go", 3'd3, 20, n);
    step(3);
    rst_n = 1'b0;
    step(1);
    checkOutput("mid_rst_state", state_o, 3'd0);
    checkOutput("mid_rst_led", led, 4'b0000);
    checkOutput("mid_rst_score1", score1, 3'd0);
    checkOutput("mid_rst_winner", winner, 2'b00);
    checkOutput("mid_rst_react", react_ms, 16'd0);
    rst_n = 1'b1;

    // Fresh match: P1 wins three straight rounds, pressing on GO entry.
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      step(1);
      waitState("m_go", 3'd3, 20, n);
      applyStimulus(1'b1, 1'b0, 1'b1);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("m_winner", winner, 2'b01);
      checkOutput("m_react0", react_ms, 16'd0);
      checkOutput("m_score1", score1, r + 1);
      if (r < 2) waitState("m_to_arm", 3'd1, 1100, n);
      else       waitState("m_to_done", 3'd5, 1100, n);
    end
    checkOutput("done_flag", match_done, 1'b1);
    checkOutput("done_led", led, 4'b1111);

    // Restart from DONE with start_n held low: IDLE then ARM.
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(1);
    checkOutput("restart_state", state_o, 3'd0);
    checkOutput("restart_score1", score1, 3'd0);
    checkOutput("restart_winner", winner, 2'b00);
    checkOutput("restart_done", match_done, 1'b0);
    checkOutput("restart_led", led, 4'b0000);
    step(1);
    checkOutput("auto_arm", state_o, 3'd1);

    // A held button stalls ARM until released.
    applyStimulus(1'b1, 1'b0, 1'b1);
    step(5);
    checkOutput("arm_stall", state_o, 3'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    step(1);
    checkOutput("arm_release", state_o, 3'd2);

    while (cyc < 70000) step(1);
    checkOutput("lfsr_never_zero", lfsr_zero, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
